// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and the load-extension helper for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Picks the addressed little-endian lane and widens it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: result = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: result = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with per-byte write enables and a registered, enable-gated read port.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[index];
        end
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Request/response data-memory slave: one outstanding access, programmable wait states,
// byte/half/word lanes with RV32 load extension and an error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIMIT = (ADDR_WIDTH-2)'(MEM_DEPTH_WORDS);

    state_t                 state, next_state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   lat_we, lat_unsigned, rdata_ok;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DATA_WIDTH-1:0]  lat_wdata;
    logic [1:0]             lat_size;

    logic                   accept, complete, enter_resp, req_err, mem_we, mem_re;
    logic                   cur_we;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [DATA_WIDTH-1:0]  cur_wdata;
    logic [1:0]             cur_size;
    logic [3:0]             mem_be;
    logic [31:0]            mem_wdata, mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_WIDTH'(1)) next_state = RESP;
            RESP:    if (complete) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the acceptance edge, so the
    // request being checked and written comes straight from the inputs there.
    always_comb begin
        accept     = (state == IDLE) && req_valid && req_ready;
        complete   = (state == RESP) && resp_valid && resp_ready;
        enter_resp = (state != RESP) && (next_state == RESP);

        cur_we    = (state == IDLE) ? req_we    : lat_we;
        cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
        cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
        cur_size  = (state == IDLE) ? req_size  : lat_size;

        req_err = (cur_size == 2'd3)
               || ((cur_size == SZ_HALF) && cur_addr[0])
               || ((cur_size == SZ_WORD) && (cur_addr[1:0] != 2'b00))
               || (cur_addr[ADDR_WIDTH-1:2] >= DEPTH_LIMIT);

        case (cur_size)
            SZ_BYTE: begin
                mem_be    = 4'b0001 << cur_addr[1:0];
                mem_wdata = {4{cur_wdata[7:0]}};
            end
            SZ_HALF: begin
                mem_be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{cur_wdata[15:0]}};
            end
            default: begin
                mem_be    = 4'b1111;
                mem_wdata = cur_wdata;
            end
        endcase

        mem_we = enter_resp && cur_we && !req_err;
        mem_re = enter_resp && !cur_we && !req_err;

        resp_rdata = rdata_ok ? load_extend(mem_rdata, lat_size, lat_addr[1:0], lat_unsigned) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            busy         <= 1'b0;
            rdata_ok     <= 1'b0;
            cnt          <= '0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= SZ_BYTE;
        end else begin
            req_ready  <= (next_state == IDLE);
            resp_valid <= (next_state == RESP);
            busy       <= (next_state != IDLE);
            if (accept) begin
                lat_we       <= req_we;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_size     <= req_size;
                cnt          <= CNT_WIDTH'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_WIDTH'(1);
            end
            if (enter_resp) begin
                resp_err <= req_err;
                rdata_ok <= !cur_we && !req_err;
            end else if (complete) begin
                resp_err <= 1'b0;
                rdata_ok <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH (MEM_DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .be    (mem_be),
        .index (cur_addr[IDX_W+1:2]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state instance and a 0-wait-state instance share one
// stimulus path; expected responses flow through a scoreboard queue.
module tb_dmem_responder;

    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic        clk, rst2, rst0, sel;
    logic        req_valid, req_we, req_unsigned, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        rdy2, rv2, err2, busy2, rdy0, rv0, err0, busy0;
    logic [31:0] rdata2, rdata0;
    logic        rdy, rv, err, busy;
    logic [31:0] rdata;

    logic [32:0] sb_queue [$];
    int checks = 0;
    int errors = 0;
    vec_t vecs [24];

    assign rdy   = sel ? rdy0   : rdy2;
    assign rv    = sel ? rv0    : rv2;
    assign err   = sel ? err0   : err2;
    assign busy  = sel ? busy0  : busy2;
    assign rdata = sel ? rdata0 : rdata2;

    dmem_responder #(.WAIT_CYCLES(2)) dut (
        .clk (clk), .rst (rst2),
        .req_valid (req_valid & ~sel), .req_ready (rdy2),
        .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata),
        .req_size (req_size), .req_unsigned (req_unsigned),
        .resp_valid (rv2), .resp_ready (resp_ready & ~sel),
        .resp_rdata (rdata2), .resp_err (err2), .busy (busy2)
    );

    dmem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk (clk), .rst (rst0),
        .req_valid (req_valid & sel), .req_ready (rdy0),
        .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata),
        .req_size (req_size), .req_unsigned (req_unsigned),
        .resp_valid (rv0), .resp_ready (resp_ready & sel),
        .resp_rdata (rdata0), .resp_err (err0), .busy (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkResponse(input string name);
        logic [32:0] e;
        if (sb_queue.size() == 0) begin
            checkOutput({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_queue.pop_front();
            checkOutput({name, "_rdata"}, rdata, e[31:0]);
            checkOutput({name, "_err"}, {31'b0, err}, {31'b0, e[32]});
        end
    endtask

    // Waits for req_ready, presents the request for one accepting edge, then scrambles the
    // request fields so a responder that keeps sampling them while busy is caught.
    task automatic issueRequest(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, input logic push,
                                input logic [31:0] exp_rdata, input logic exp_err, output logic ok);
        int n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = rdy;
        if (!ok) begin
            checkOutput("req_ready_timeout", {31'b0, rdy}, 32'd1);
            return;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        @(posedge clk);
        if (push) sb_queue.push_back({exp_err, exp_rdata});
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = ~uns;
    endtask

    task automatic waitResponse(input string name, output logic ok);
        int n = 1;
        while (!rv && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = rv;
        checkOutput({name, "_latency"}, n, sel ? 32'd1 : 32'd3);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        logic ok;
        string name;
        name = $sformatf("vec%0d", idx);
        sel = v.sel;
        @(negedge clk);
        issueRequest(v.we, v.addr, v.wdata, v.size, v.uns, 1'b1, v.rdata, v.err, ok);
        if (!ok) return;
        waitResponse(name, ok);
        if (!ok) begin
            void'(sb_queue.pop_front());
            return;
        end
        checkResponse(name);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput({name, "_done_valid"}, {31'b0, rv}, 32'd0);
        checkOutput({name, "_done_ready"}, {31'b0, rdy}, 32'd1);
    endtask

    initial begin
        logic ok, saw_valid;
        vec_t v;

        vecs[0]  = '{0, 1, 32'h00, 32'h0BADF00D, 2'd2, 0, 32'h0, 0};
        vecs[1]  = '{0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0};
        vecs[2]  = '{0, 1, 32'h20, 32'h11112222, 2'd2, 0, 32'h0, 0};
        vecs[3]  = '{0, 0, 32'h10, 32'h0,        2'd2, 0, 32'hDEADBEEF, 0};
        vecs[4]  = '{0, 0, 32'h13, 32'h0,        2'd0, 0, 32'hFFFFFFDE, 0};
        vecs[5]  = '{0, 0, 32'h13, 32'h0,        2'd0, 1, 32'h000000DE, 0};
        vecs[6]  = '{0, 0, 32'h10, 32'h0,        2'd1, 0, 32'hFFFFBEEF, 0};
        vecs[7]  = '{0, 1, 32'h11, 32'hFFFFFF55, 2'd0, 0, 32'h0, 0};
        vecs[8]  = '{0, 0, 32'h10, 32'h0,        2'd2, 0, 32'hDEAD55EF, 0};
        vecs[9]  = '{0, 0, 32'h12, 32'h0,        2'd1, 1, 32'h0000DEAD, 0};
        vecs[10] = '{0, 0, 32'h11, 32'h0,        2'd0, 0, 32'h00000055, 0};
        vecs[11] = '{0, 0, 32'h11, 32'h0,        2'd1, 0, 32'h0, 1};
        vecs[12] = '{0, 1, 32'h1000, 32'hCAFEF00D, 2'd2, 0, 32'h0, 1};
        vecs[13] = '{0, 0, 32'h00, 32'h0,        2'd2, 0, 32'h0BADF00D, 0};
        vecs[14] = '{0, 0, 32'h00, 32'h0,        2'd3, 0, 32'h0, 1};
        vecs[15] = '{0, 0, 32'h12, 32'h0,        2'd2, 0, 32'h0, 1};
        vecs[16] = '{0, 1, 32'h02, 32'h12348001, 2'd1, 0, 32'h0, 0};
        vecs[17] = '{0, 0, 32'h00, 32'h0,        2'd2, 0, 32'h8001F00D, 0};
        vecs[18] = '{0, 0, 32'h02, 32'h0,        2'd1, 0, 32'hFFFF8001, 0};
        vecs[19] = '{0, 0, 32'h10, 32'h0,        2'd2, 1, 32'hDEAD55EF, 0};
        vecs[20] = '{1, 1, 32'h40, 32'hA5A55A5A, 2'd2, 0, 32'h0, 0};
        vecs[21] = '{1, 0, 32'h40, 32'h0,        2'd2, 0, 32'hA5A55A5A, 0};
        vecs[22] = '{1, 0, 32'h42, 32'h0,        2'd0, 0, 32'hFFFFFFA5, 0};
        vecs[23] = '{1, 0, 32'h41, 32'h0,        2'd1, 0, 32'h0, 1};

        sel = 1'b0; rst2 = 1'b0; rst0 = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;

        // Reset values, then req_ready on the first edge after release.
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", {31'b0, rdy2}, 32'd0);
        checkOutput("reset_resp_valid", {31'b0, rv2}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy2}, 32'd0);
        checkOutput("reset_rdata", rdata2, 32'd0);
        checkOutput("reset_err", {31'b0, err2}, 32'd0);
        checkOutput("reset_req_ready0", {31'b0, rdy0}, 32'd0);
        rst2 = 1'b1; rst0 = 1'b1;
        @(negedge clk);
        checkOutput("release_req_ready", {31'b0, rdy2}, 32'd1);
        checkOutput("release_req_ready0", {31'b0, rdy0}, 32'd1);

        for (int i = 0; i < 24; i++) begin
            v = vecs[i];
            applyStimulus(v, i);
        end

        // Backpressure: response must hold still while resp_ready is low.
        sel = 1'b0;
        @(negedge clk);
        issueRequest(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b1, 32'hDEAD55EF, 1'b0, ok);
        if (ok) begin
            checkOutput("bp_busy", {31'b0, busy}, 32'd1);
            waitResponse("bp", ok);
            if (ok) begin
                for (int k = 0; k < 5; k++) begin
                    checkOutput("bp_hold_valid", {31'b0, rv}, 32'd1);
                    checkOutput("bp_hold_rdata", rdata, 32'hDEAD55EF);
                    checkOutput("bp_hold_err", {31'b0, err}, 32'd0);
                    checkOutput("bp_hold_req_ready", {31'b0, rdy}, 32'd0);
                    @(negedge clk);
                end
                checkResponse("bp");
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
                checkOutput("bp_done_req_ready", {31'b0, rdy}, 32'd1);
                checkOutput("bp_done_valid", {31'b0, rv}, 32'd0);
                checkOutput("bp_done_rdata", rdata, 32'd0);
                checkOutput("bp_done_busy", {31'b0, busy}, 32'd0);
            end else begin
                void'(sb_queue.pop_front());
            end
        end

        // Reset while a store waits: the store must never reach memory.
        @(negedge clk);
        issueRequest(1'b1, 32'h20, 32'h12345678, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0, ok);
        if (ok) begin
            checkOutput("rstwait_busy", {31'b0, busy}, 32'd1);
            rst2 = 1'b0;
            #1;
            checkOutput("rstwait_busy_low", {31'b0, busy}, 32'd0);
            checkOutput("rstwait_req_ready", {31'b0, rdy}, 32'd0);
            saw_valid = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (rv) saw_valid = 1'b1;
            end
            rst2 = 1'b1;
            @(negedge clk);
            if (rv) saw_valid = 1'b1;
            checkOutput("rstwait_req_ready_after", {31'b0, rdy}, 32'd1);
            checkOutput("rstwait_no_response", {31'b0, saw_valid}, 32'd0);
        end
        v = '{0, 0, 32'h20, 32'h0, 2'd2, 0, 32'h11112222, 0};
        applyStimulus(v, 100);

        checkOutput("sb_drained", sb_queue.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
